// File: rtl/per_bus_sequencer.sv
// Command-driven master for the openMSP430 peripheral bus: WRITE/READ/POLL/WAIT commands
// become registered single-cycle bus accesses, each answered by one response pulse.
module per_bus_sequencer #(
    parameter int unsigned POLL_TIMEOUT = 1024,
    parameter int unsigned POLL_GAP     = 4
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [13:0] cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic [15:0] cmd_mask,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [13:0] per_addr,
    output logic        per_en,
    output logic [1:0]  per_wen,
    output logic [15:0] per_din,
    input  logic [15:0] per_dout,
    output logic        busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAccess = 3'd1;
    localparam logic [2:0] StGap    = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StResp   = 3'd4;

    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpPoll  = 2'b10;
    localparam logic [1:0] OpWait  = 2'b11;

    localparam logic [16:0] TimeoutW = 17'(POLL_TIMEOUT);
    localparam logic [15:0] GapLoad  = (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] reads_q, reads_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        per_en_q, per_en_d;
    logic [13:0] per_addr_q, per_addr_d;
    logic [1:0]  per_wen_q, per_wen_d;
    logic [15:0] per_din_q, per_din_d;

    logic poll_match;
    logic poll_last;

    assign cmd_ready  = (state_q == StIdle) && !puc_rst;
    assign poll_match = ((per_dout & mask_q) == (data_q & mask_q));
    assign poll_last  = (({1'b0, reads_q} + 17'd1) >= TimeoutW);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        reads_d    = reads_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    mask_d  = cmd_mask;
                    reads_d = 16'd0;
                    if (cmd_op == OpWait) begin
                        cnt_d   = cmd_data;
                        state_d = StWait;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (op_q == OpPoll) begin
                    reads_d = reads_q + 16'd1;
                    if (poll_match || poll_last) begin
                        state_d    = StResp;
                        rsp_data_d = per_dout;
                        rsp_err_d  = !poll_match;
                    end else if (POLL_GAP == 0) begin
                        state_d = StAccess;
                    end else begin
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end
                end else begin
                    state_d    = StResp;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = (op_q == OpRead) ? per_dout : data_q;
                end
            end
            StGap: begin
                if (cnt_q == 16'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StWait: begin
                if (cnt_q == 16'd0) begin
                    state_d    = StResp;
                    rsp_data_d = data_q;
                    rsp_err_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Bus outputs are registered, so they are derived from the next-state values.
        rsp_valid_d = (state_d == StResp);
        per_en_d    = (state_d == StAccess);
        per_addr_d  = per_en_d ? addr_d : 14'd0;
        per_wen_d   = (per_en_d && (op_d == OpWrite)) ? 2'b11 : 2'b00;
        per_din_d   = (per_en_d && (op_d == OpWrite)) ? data_d : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (puc_rst) begin
            state_q     <= StIdle;
            op_q        <= 2'b00;
            addr_q      <= 14'd0;
            data_q      <= 16'd0;
            mask_q      <= 16'd0;
            cnt_q       <= 16'd0;
            reads_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_err_q   <= 1'b0;
            per_en_q    <= 1'b0;
            per_addr_q  <= 14'd0;
            per_wen_q   <= 2'b00;
            per_din_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            reads_q     <= reads_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            per_en_q    <= per_en_d;
            per_addr_q  <= per_addr_d;
            per_wen_q   <= per_wen_d;
            per_din_q   <= per_din_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign per_en    = per_en_q;
    assign per_addr  = per_addr_q;
    assign per_wen   = per_wen_q;
    assign per_din   = per_din_q;
    assign busy      = (state_q != StIdle);

endmodule
